aes_key_expand: RTL and testbench

Sequential AES-128 key schedule that sits directly upstream of the round-key XOR stage. It turns one 128-bit cipher key into the 11 round keys (rounds 0..10), one key per clock. Each key is presented on round_key with a round index and a valid strobe, so the downstream stage can use it on its enable. One expansion runs per start pulse; the optional hold input stalls generation.

---
 rtl/aes_key_expand.sv | 137 +++++++++++++
 tb/tb_aes_key_expand.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// aes_key_expand - sequential AES-128 key schedule.
//
// Expands one 128-bit cipher key into the eleven round keys (rounds 0..10),
// one key per clock, for the round-key XOR stage that follows.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      one-cycle pulse; begins an expansion of key_in (IDLE only)
//   key_in     cipher key, sampled on the start cycle; byte 0 = [127:120]
//   hold       stall; freezes every register while asserted in EXPAND
//   round_key  current round key, w0 = [127:96] .. w3 = [31:0]
//   round_idx  round index (0..10) of round_key
//   key_valid  round_key/round_idx are valid this cycle
//   busy       high from the cycle after start until the cycle after done
//   done       one-cycle pulse alongside the round 10 key (held during hold)
module aes_key_expand #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         hold,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_IDX   = 4'(NR);
    localparam logic [3:0] PENULT_IDX = 4'(NR - 1);

    // AES S-box; entry 0 occupies the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    state_t      state;
    logic [7:0]  rcon;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  t;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;
    logic [7:0]   rcon_next;

    // Byte b lives at bit offset (255 - b) * 8, and 255 - b == ~b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    always_comb begin
        w0 = round_key[127:96];
        w1 = round_key[95:64];
        w2 = round_key[63:32];
        w3 = round_key[31:0];
        // RotWord then SubWord, with the round constant in the top byte.
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key  = {n0, n1, n2, n3};
        rcon_next = rcon[7] ? ({rcon[6:0], 1'b0} ^ 8'h1b) : {rcon[6:0], 1'b0};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            round_key <= '0;
            round_idx <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rcon      <= 8'h01;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        round_key <= key_in;
                        round_idx <= '0;
                        key_valid <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        rcon      <= 8'h01;
                        state     <= EXPAND;
                    end
                end
                EXPAND: begin
                    // hold freezes everything, so done stays up while the
                    // round 10 key is being held.
                    if (!hold) begin
                        if (round_idx < LAST_IDX) begin
                            round_key <= next_key;
                            round_idx <= round_idx + 4'd1;
                            rcon      <= rcon_next;
                            done      <= (round_idx == PENULT_IDX);
                        end else begin
                            key_valid <= 1'b0;
                            done      <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand - scoreboard bench for aes_key_expand.
//
// Stimulus pushes the expected per-cycle key presentations into a queue;
// a monitor on the falling edge pops one entry for every cycle key_valid is
// high and compares key, index and done.
`timescale 1ns/1ps
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         hold = 1'b0;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    aes_key_expand #(.NR(10)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .key_in    (key_in),
        .hold      (hold),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    localparam logic [127:0] ZERO_RK [0:10] = '{
        128'h00000000000000000000000000000000,
        128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
        128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b,
        128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7,
        128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f,
        128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e
    };

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   idx;
        logic         dn;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   t_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Queue one expansion; the held round appears once per held cycle.
    task automatic push_sched(input logic use_fips, input int hold_at, input int hold_len);
        for (int r = 0; r <= 10; r++) begin
            int reps;
            reps = (r == hold_at) ? 1 + hold_len : 1;
            for (int k = 0; k < reps; k++) begin
                exp_t e;
                e.key = use_fips ? FIPS_RK[r] : ZERO_RK[r];
                e.idx = 4'(r);
                e.dn  = (r == 10);
                exp_q.push_back(e);
            end
        end
    endtask

    // Called #1 after a rising edge (edge T); start is sampled at T+1.
    task automatic start_exp(input logic [127:0] k);
        key_in  = k;
        start   = 1'b1;
        t_start = cyc;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = ~k;
        chk("busy_rise", 128'(busy), 128'(1));
    endtask

    task automatic wait_idx(input int target, input string name);
        int n;
        n = 0;
        while (round_idx != 4'(target) && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 128'(round_idx), 128'(target));
    endtask

    task automatic wait_done(input int lat, input string name);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_done_seen"}, 128'(done), 128'(1));
        chk({name, "_done_lat"}, 128'(cyc - t_start), 128'(lat));
        @(posedge clk);
        #1;
        chk({name, "_busy_fall"}, 128'(busy), 128'(0));
        chk({name, "_valid_fall"}, 128'(key_valid), 128'(0));
        chk({name, "_done_fall"}, 128'(done), 128'(0));
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_key: got idx %0d key %h, expected no key", round_idx, round_key);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("rk%0d_key", e.idx), round_key, e.key);
                    chk($sformatf("rk%0d_idx", e.idx), 128'(round_idx), 128'(e.idx));
                    chk($sformatf("rk%0d_done", e.idx), 128'(done), 128'(e.dn));
                end
            end else if (done) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_without_valid: got done 1 expected 0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_key", round_key, 128'h0);
        chk("rst_idx", 128'(round_idx), 128'(0));
        chk("rst_valid", 128'(key_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 vector
        push_sched(1'b1, -1, 0);
        start_exp(FIPS_KEY);
        wait_done(11, "fips");

        // Back-to-back: start on the first idle cycle after done
        push_sched(1'b0, -1, 0);
        start_exp(ZERO_KEY);
        wait_done(11, "zero");

        // hold for 3 cycles at round 4
        push_sched(1'b1, 4, 3);
        start_exp(FIPS_KEY);
        wait_idx(4, "hold_reach4");
        hold = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("hold_idx", 128'(round_idx), 128'(4));
        chk("hold_key", round_key, FIPS_RK[4]);
        chk("hold_valid", 128'(key_valid), 128'(1));
        hold = 1'b0;
        wait_done(14, "hold");

        // Second start during EXPAND is ignored
        push_sched(1'b1, -1, 0);
        start_exp(FIPS_KEY);
        wait_idx(5, "restart_reach5");
        key_in = 128'hffeeddccbbaa99887766554433221100;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(11, "ignore_start");

        // Asynchronous reset mid-expansion
        push_sched(1'b1, -1, 0);
        start_exp(FIPS_KEY);
        wait_idx(7, "abort_reach7");
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_key", round_key, 128'h0);
        chk("abort_idx", 128'(round_idx), 128'(0));
        chk("abort_valid", 128'(key_valid), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_done", 128'(done), 128'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_idle_valid", 128'(key_valid), 128'(0));
        push_sched(1'b0, -1, 0);
        start_exp(ZERO_KEY);
        wait_done(11, "after_abort");

        // start held high: one restart per completed expansion
        push_sched(1'b1, -1, 0);
        push_sched(1'b1, -1, 0);
        key_in  = FIPS_KEY;
        start   = 1'b1;
        t_start = cyc;
        wait_done(11, "cont1");
        t_start = cyc;
        wait_done(11, "cont2");
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("cont_stopped", 128'(busy), 128'(0));

        // Scoreboard must be fully drained
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
